// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//   Two-requester round-robin front end feeding a bit-serial adder.
//   One operation is in flight at a time: IDLE grants and latches
//   operands, ADD produces one sum bit per cycle (LSB first), and DONE
//   holds the result until the consumer takes it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/a/b/ready    requester N (N = 0,1) operand handshake
//   res_valid/ready         result handshake
//   res_sum                 (a+b) mod 2^WIDTH
//   res_carry               bit WIDTH of a+b
//   res_id                  requester that owns the result
//   busy                    high whenever not IDLE
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;

  logic grant0, grant1, accept, res_hs;
  logic bit_a, bit_b, h_sum, h_carry, s_bit, c_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
    end
  end

  always_comb begin
    // On a tie the requester that did not own the previous result wins.
    grant0 = req0_valid && (!req1_valid || last_id_q);
    grant1 = req1_valid && (!req0_valid || !last_id_q);

    // Ready is gated by rst_n so it drops the instant reset asserts,
    // even while a requester keeps its valid high.
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    res_valid = (state_q == DONE);
    res_hs    = res_valid && res_ready;
    res_sum   = sum_q;
    res_carry = carry_q;
    res_id    = id_q;
    busy      = (state_q != IDLE);

    // Shared 1-bit cell built from two half-adder stages.
    bit_a   = a_q[cnt_q];
    bit_b   = b_q[cnt_q];
    h_sum   = bit_a ^ bit_b;
    h_carry = bit_a & bit_b;
    s_bit   = h_sum ^ carry_q;
    c_next  = h_carry | (h_sum & carry_q);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = grant0 ? req0_a : req1_a;
          b_d     = grant0 ? req0_b : req1_b;
          id_d    = grant1;
          carry_d = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[cnt_q] = s_bit;
        carry_d      = c_next;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_hs) begin
          last_id_d = id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_carry, res_id, res_ready, busy;
  logic [W-1:0] res_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 1'b0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else            begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    res_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Waits (bounded) for res_valid, counting cycles since the accepting edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (res_valid === 1'b1) break;
    end
    chk("res_valid_seen", res_valid, 1);
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic rid, output int lat);
    int n;
    @(negedge clk);
    set_req(id, 1'b1, a, b);
    res_ready = 1;
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("op_ready_seen", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    // operands must be ignored after the accepting edge
    set_req(id, 1'b0, W'($urandom), W'($urandom));
    wait_result(lat);
    s = res_sum; c = res_carry; rid = res_id;
    @(posedge clk); #1;
    chk("op_res_valid_after_hs", res_valid, 0);
  endtask

  initial begin
    logic [W-1:0] s, s0;
    logic         c, c0, rid, id0;
    int           lat;

    tbl[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[3] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
    tbl[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[5] = '{1'b1, 8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[6] = '{1'b0, 8'h01, 8'h7F, 8'h80, 1'b0};
    tbl[7] = '{1'b1, 8'h0F, 8'hF1, 8'h00, 1'b1};

    // ---- reset state, with both valids high during reset ----
    rst_n = 0; res_ready = 0; clear_inputs();
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_carry", res_carry, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;

    // ---- table-driven single operations ----
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].id, tbl[i].a, tbl[i].b, s, c, rid, lat);
      chk($sformatf("tbl%0d_latency", i), lat, W + 1);
      chk($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
      chk($sformatf("tbl%0d_carry", i), c, tbl[i].carry);
      chk($sformatf("tbl%0d_id", i), rid, tbl[i].id);
    end

    // ---- tie after reset: req0 first, then req1, then req0 wins again ----
    do_reset();
    @(negedge clk);
    set_req(0, 1, 8'h0F, 8'h01);
    set_req(1, 1, 8'hAA, 8'h55);
    res_ready = 1;
    #1;
    chk("tie1_r0", req0_ready, 1);
    chk("tie1_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    chk("tie1_busy_r1", req1_ready, 0);
    wait_result(lat);
    chk("tie1_lat", lat, W + 1);
    chk("tie1_id", res_id, 0);
    chk("tie1_sum", res_sum, 8'h10);
    chk("tie1_carry", res_carry, 0);
    @(posedge clk); #1;
    chk("tie2_r1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_result(lat);
    chk("tie2_id", res_id, 1);
    chk("tie2_sum", res_sum, 8'hFF);
    chk("tie2_carry", res_carry, 0);
    @(posedge clk); #1;
    set_req(0, 1, 8'h01, 8'h01);
    set_req(1, 1, 8'h02, 8'h02);
    #1;
    chk("tie3_r0", req0_ready, 1);
    chk("tie3_r1", req1_ready, 0);
    // withdraw before the edge: nothing may be accepted
    clear_inputs();
    @(posedge clk); #1;
    chk("drop_busy", busy, 0);

    // ---- back-pressure in DONE ----
    @(negedge clk);
    set_req(0, 1, 8'h3C, 8'h4D);
    res_ready = 0;
    @(posedge clk); #1;
    set_req(0, 1, 8'hFF, 8'hFF);
    set_req(1, 1, 8'hFF, 8'hFF);
    wait_result(lat);
    s0 = res_sum; c0 = res_carry; id0 = res_id;
    chk("bp_sum", s0, 8'h89);
    chk("bp_carry", c0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_sum_hold", res_sum, 8'h89);
      chk("bp_carry_hold", res_carry, 0);
      chk("bp_id_hold", res_id, 0);
      chk("bp_busy", busy, 1);
      chk("bp_r0", req0_ready, 0);
      chk("bp_r1", req1_ready, 0);
    end
    clear_inputs();
    res_ready = 1;
    @(posedge clk); #1;
    chk("bp_done_valid", res_valid, 0);
    chk("bp_done_busy", busy, 0);

    // ---- reset in the 4th ADD cycle aborts the operation ----
    @(negedge clk);
    set_req(0, 1, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    clear_inputs();
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", res_sum, 0);
    chk("abort_carry", res_carry, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_result", res_valid, 0);
    end
    run_op(0, 8'h12, 8'h34, s, c, rid, lat);
    chk("after_abort_sum", s, 8'h46);
    chk("after_abort_carry", c, 0);
    chk("after_abort_lat", lat, W + 1);

    // ---- random traffic against a transaction-level model ----
    do_reset();
    begin
      logic         pend[2];
      int           wait_ops[2];
      logic         inflight, mid, mlast, g0, g1, acc_any, acc, hs, exp_v;
      logic [W:0]   mres;
      logic [W-1:0] ca, cb;
      int           cyc, ops_done, cycles;
      pend[0] = 0; pend[1] = 0; wait_ops[0] = 0; wait_ops[1] = 0;
      inflight = 0; mid = 0; mlast = 1; mres = '0; cyc = 0;
      ops_done = 0; cycles = 0;
      while (ops_done < 1000 && cycles < 60000 && errors < 50) begin
        @(negedge clk);
        cycles++;
        for (int r = 0; r < 2; r++)
          if (!pend[r] && $urandom_range(3) == 0) pend[r] = 1;
        set_req(0, pend[0], W'($urandom), W'($urandom));
        set_req(1, pend[1], W'($urandom), W'($urandom));
        res_ready = ($urandom_range(2) != 0);
        #1;
        g0 = !inflight && pend[0] && (!pend[1] || mlast);
        g1 = !inflight && pend[1] && (!pend[0] || !mlast);
        exp_v = inflight && (cyc > W);
        chk("rnd_r0", req0_ready, g0);
        chk("rnd_r1", req1_ready, g1);
        chk("rnd_busy", busy, inflight);
        chk("rnd_valid", res_valid, exp_v);
        if (exp_v) begin
          chk("rnd_sum", res_sum, mres[W-1:0]);
          chk("rnd_carry", res_carry, mres[W]);
          chk("rnd_id", res_id, mid);
        end
        acc_any = g0 || g1;
        acc = g1;
        ca = acc ? req1_a : req0_a;
        cb = acc ? req1_b : req0_b;
        hs = exp_v && res_ready;
        @(posedge clk);
        if (inflight) cyc++;
        if (hs) begin
          inflight = 0;
          mlast = mid;
          ops_done++;
        end
        if (acc_any) begin
          chk("rnd_fairness", wait_ops[acc] <= 1, 1);
          wait_ops[acc] = 0;
          if (pend[!acc]) wait_ops[!acc]++;
          pend[acc] = 0;
          inflight = 1;
          cyc = 1;
          mid = acc;
          mres = {1'b0, ca} + {1'b0, cb};
        end
      end
      chk("rnd_ops_completed", ops_done, 1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid  in  1  requester 0 has operands.
REQ-005 req0_a, req0_b  in  WIDTH each  requester 0 operands.
REQ-006 req0_ready  out  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  SHALL mirror REQ-004..006 for requester 1.
REQ-008 res_valid  out  1  result available.
REQ-009 res_sum  out  WIDTH  (a+b) mod 2^WIDTH.
REQ-010 res_carry  out  1  bit WIDTH of a+b.
REQ-011 res_id  out  1  requester that owns the result.
REQ-012 res_ready  in  1  consumer takes result.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, ADD, DONE; one operation in flight at a time.
REQ-015 Grant in IDLE: one valid -> that requester; both valid -> requester != last_id; none -> no grant.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; low in ADD and DONE.
REQ-017 On valid&&ready: latch a, b, id; clear carry flop and bit counter; IDLE -> ADD next edge.
REQ-018 Dropping reqN_valid before acceptance SHALL have no effect on state.
REQ-019 ADD: one bit per cycle, LSB first, via one shared 1-bit cell of two half-adder stages: s = a[i]^b[i]^c, c' = a[i]&b[i] | c&(a[i]^b[i]).
REQ-020 Sum bit i SHALL be written to res_sum[i]; carry flop updated each ADD cycle.
REQ-021 After exactly WIDTH ADD cycles: ADD -> DONE; res_carry = final carry; res_id = latched id.
REQ-022 Latency: res_valid high in the WIDTH+1th cycle after the accepting edge (9 cycles for WIDTH=8).
REQ-023 DONE: res_valid high; res_sum, res_carry, res_id SHALL hold stable until res_valid&&res_ready.
REQ-024 On res_valid&&res_ready: last_id <= res_id; res_valid low; DONE -> IDLE next edge.
REQ-025 Next acceptance SHALL occur no earlier than the cycle after the result handshake.
REQ-026 Operand inputs SHALL be ignored outside the accepting cycle.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, res_valid 0, res_sum 0, res_carry 0, res_id 0, busy 0, req0_ready 0, req1_ready 0, last_id 1 (req0 wins the first tie).
REQ-028 Reset in ADD or DONE SHALL abort the operation; no result SHALL be produced for it.
REQ-029 Operation after reset release SHALL be fully correct with no residue from the aborted operation.

Verification
REQ-030 req0 0x00+0x00, res_ready=1 -> res_valid 9 cycles later, sum 0x00, carry 0, id 0.
REQ-031 req1 0xFF+0x01 -> sum 0x00, carry 1, id 1; 0xFF+0xFF -> sum 0xFE, carry 1.
REQ-032 Both valid after reset, req0 0x0F+0x01, req1 0xAA+0x55 -> first result id 0 sum 0x10 carry 0, then id 1 sum 0xFF carry 0; on the next tie req0 wins.
REQ-033 res_ready low 5 cycles in DONE -> outputs stable, busy 1, both ready low; result completes on res_ready high.
REQ-034 rst_n pulsed low on the 4th ADD cycle -> res_valid 0, busy 0 immediately; next op 0x12+0x34 -> 0x46, carry 0.
REQ-035 Random operands, random valid/ready over 1000 ops -> every result equals a+b, none lost or duplicated, no requester waits more than one operation while the other is valid.
